// File: rtl/xup_reg_write_arbiter.sv
// Round-robin write arbiter and sequencer for a shared enable-gated register.
// Requesters use a req/ack handshake. Each grant produces one write strobe, then one ack pulse.
module xup_reg_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int HOLD  = 1,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        q,
  output logic                    en_out,
  output logic [IDW-1:0]          gnt_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] staging;
  logic [IDW-1:0]   last_grant;
  logic [3:0]       gap_cnt;
  logic [IDW-1:0]   winner;
  logic [WIDTH-1:0] win_data;
  logic             any_req;

  assign any_req = |req;

  // Pass 1 picks the lowest requester at or below the pointer (the wrapped candidates).
  // Pass 2 overrides it with the lowest requester strictly above the pointer, if there is one.
  always_comb begin
    winner   = '0;
    win_data = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(last_grant))) begin
        winner   = IDW'(i);
        win_data = wdata[i*WIDTH +: WIDTH];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last_grant))) begin
        winner   = IDW'(i);
        win_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    next_state = state;
    en_out     = 1'b0;
    ack        = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) next_state = WRITE;
      end
      WRITE: begin
        en_out     = 1'b1;
        next_state = ACK;
      end
      ACK: begin
        ack        = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
        next_state = (HOLD > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt <= 4'd1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Data is captured into staging at the grant edge, so later wdata changes cannot affect the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      gnt_id     <= '0;
      staging    <= '0;
      last_grant <= IDW'(NREQ - 1);
      gap_cnt    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id  <= winner;
            staging <= win_data;
          end
        end
        WRITE: begin
          q <= staging;
        end
        ACK: begin
          last_grant <= gnt_id;
          gap_cnt    <= 4'(HOLD);
        end
        GAP: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xup_reg_write_arbiter.sv
// Directed bench for xup_reg_write_arbiter.
// Instance dut uses HOLD=1 and instance dut0 uses HOLD=0.
module tb_xup_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        en_out;
  logic [1:0]  gnt_id;
  logic        busy;

  logic [3:0]  req_b;
  logic [31:0] wdata_b;
  logic [3:0]  ack_b;
  logic [7:0]  q_b;
  logic        en_b;
  logic [1:0]  gnt_b;
  logic        busy_b;

  int errors = 0;
  int checks = 0;
  int en_count;

  always #5 clk = ~clk;

  xup_reg_write_arbiter #(.WIDTH(8), .NREQ(4), .HOLD(1)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .ack(ack), .q(q), .en_out(en_out), .gnt_id(gnt_id), .busy(busy)
  );

  xup_reg_write_arbiter #(.WIDTH(8), .NREQ(4), .HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .req(req_b), .wdata(wdata_b),
    .ack(ack_b), .q(q_b), .en_out(en_b), .gnt_id(gnt_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] w);
    req   = r;
    wdata = w;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete HOLD=1 transaction, starting in IDLE with req already applied.
  task automatic expectWrite(input string tag, input int id, input logic [7:0] data);
    step();
    checkOutput({tag, "_gnt"}, 32'(gnt_id), id);
    checkOutput({tag, "_en"}, 32'(en_out), 1);
    step();
    checkOutput({tag, "_q"}, 32'(q), 32'(data));
    checkOutput({tag, "_ack"}, 32'(ack), 1 << id);
    step();
    checkOutput({tag, "_gap_busy"}, 32'(busy), 1);
    checkOutput({tag, "_gap_ack"}, 32'(ack), 0);
    step();
    checkOutput({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    reset   = 1'b1;
    req_b   = 4'b0000;
    wdata_b = 32'h0;
    applyStimulus(4'b0000, 32'h0);
    step();
    step();
    reset = 1'b0;
    $display("[TB] reset and single request");
    checkOutput("rst_q", 32'(q), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ack", 32'(ack), 0);
    checkOutput("rst_en", 32'(en_out), 0);
    checkOutput("rst_gnt", 32'(gnt_id), 0);

    applyStimulus(4'b0100, 32'h00A5_0000);
    step();
    checkOutput("single_en", 32'(en_out), 1);
    checkOutput("single_gnt", 32'(gnt_id), 2);
    checkOutput("single_q_before", 32'(q), 0);
    checkOutput("single_ack_write", 32'(ack), 0);
    applyStimulus(4'b0100, 32'h0);
    step();
    checkOutput("single_q", 32'(q), 32'hA5);
    checkOutput("single_ack", 32'(ack), 32'b0100);
    checkOutput("single_en_ack", 32'(en_out), 0);
    applyStimulus(4'b0000, 32'h0);
    step();
    checkOutput("single_ack_gap", 32'(ack), 0);
    checkOutput("single_gnt_hold", 32'(gnt_id), 2);
    step();
    checkOutput("single_idle", 32'(busy), 0);
    checkOutput("single_q_hold", 32'(q), 32'hA5);

    $display("[TB] all requesters, round robin");
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(4'b1111, 32'h1312_1110);
    for (int g = 0; g < 5; g++) begin
      expectWrite("rr", g % 4, 8'(8'h10 + g % 4));
    end

    $display("[TB] fairness after wrap");
    applyStimulus(4'b1000, 32'h1312_1110);
    expectWrite("wrap_a", 3, 8'h13);
    applyStimulus(4'b1001, 32'h4400_0011);
    expectWrite("wrap_b", 0, 8'h11);
    expectWrite("wrap_c", 3, 8'h44);
    applyStimulus(4'b0000, 32'h0);

    $display("[TB] data stability and dropped req");
    applyStimulus(4'b0010, 32'h0000_3300);
    step();
    checkOutput("stab_gnt", 32'(gnt_id), 1);
    applyStimulus(4'b0000, 32'h0000_CC00);
    step();
    checkOutput("stab_q", 32'(q), 32'h33);
    checkOutput("stab_ack", 32'(ack), 32'b0010);
    step();
    step();
    checkOutput("stab_idle", 32'(busy), 0);

    $display("[TB] reset mid-operation");
    applyStimulus(4'b0001, 32'h0000_0077);
    step();
    checkOutput("midrst_en", 32'(en_out), 1);
    reset = 1'b1;
    applyStimulus(4'b0000, 32'h0);
    step();
    reset = 1'b0;
    checkOutput("midrst_q", 32'(q), 0);
    checkOutput("midrst_ack", 32'(ack), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    applyStimulus(4'b1000, 32'h5A00_0000);
    expectWrite("midrst_after", 3, 8'h5A);
    applyStimulus(4'b0000, 32'h0);

    $display("[TB] HOLD=0 back-to-back");
    req_b    = 4'b0011;
    wdata_b  = 32'h0000_E1E0;
    en_count = 0;
    for (int g = 0; g < 4; g++) begin
      step();
      en_count += int'(en_b);
      checkOutput("h0_gnt", 32'(gnt_b), g % 2);
      step();
      en_count += int'(en_b);
      checkOutput("h0_q", 32'(q_b), 32'(8'hE0 + g % 2));
      checkOutput("h0_ack", 32'(ack_b), 1 << (g % 2));
      step();
      en_count += int'(en_b);
      checkOutput("h0_idle", 32'(busy_b), 0);
    end
    checkOutput("h0_en_duty", 32'(en_count), 4);
    req_b = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xup_reg_write_arbiter.md
Name: xup_reg_write_arbiter

Overview:
- Round-robin write arbiter and sequencer for a shared WIDTH-bit enabled register, built internally as a bank of enable-gated D flip-flops.
- NREQ requesters compete for write access using a req/ack handshake.
- The block generates the single write-enable strobe and selects the data source for each write.
- It sits between the user-logic requesters and the shared register; the register value drives downstream logic such as display or LEDs.

Parameters:
- WIDTH, 8: register and per-requester data width, 1..32.
- NREQ, 4: number of requesters, 2..8.
- HOLD, 1: idle gap cycles inserted after each ack before the next arbitration, 0..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester write request, level-sensitive.
- wdata  in  NREQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- q  out  WIDTH  shared register contents.
- en_out  out  1  write strobe, high in the cycle the register loads.
- gnt_id  out  clog2(NREQ), minimum 1  index of the current or last granted requester.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values, applied on the clk edge where reset=1: state=IDLE, q=0, ack=0, en_out=0, gnt_id=0, busy=0, staging=0, last-grant pointer=NREQ-1 (so requester 0 wins first), gap counter=0.
- Reset has priority over every other action. Reset mid-operation abandons the transaction: no ack is issued and q is cleared.
- FSM states: IDLE, WRITE, ACK, GAP.
- IDLE:
  - If req is nonzero at edge E, select the winner by round-robin: first asserted index searching upward from (last-grant+1) mod NREQ.
  - At edge E, register gnt_id=winner and latch that requester's wdata into staging; go to WRITE.
  - If req is zero, stay in IDLE.
- WRITE (cycle E..E+1):
  - en_out=1.
  - At edge E+1, q<=staging; go to ACK.
- ACK (cycle E+1..E+2):
  - ack[gnt_id]=1, all other ack bits 0.
  - At edge E+2, last-grant<=gnt_id.
  - Next state: GAP with counter=HOLD if HOLD>0, otherwise IDLE.
- GAP:
  - Decrement the counter each cycle; go to IDLE at the edge where the counter reaches 1.
  - req is ignored in GAP.
- Latency: req sampled at edge E; q updated at E+1; ack high during E+1..E+2. The earliest next arbitration edge is E+3+HOLD.
- Requester protocol:
  - Hold req and wdata until ack is seen.
  - Deassert req in the cycle after ack if no further write is wanted. A req still high when IDLE next samples counts as a new request.
- Data is captured at the grant edge. wdata changes after grant do not affect the write.
- If the winner drops req during WRITE or ACK, the write still completes and ack still pulses.
- Simultaneous requests:
  - The round-robin order guarantees service within NREQ grants.
  - A new req arriving during WRITE, ACK or GAP waits until IDLE.
- q holds its value between writes; only en_out cycles modify it.
- en_out and ack are never both high. At most one ack bit is high at any time.
- Pointer wrap: last-grant=NREQ-1 searches from index 0.
- gnt_id holds its value after ACK until the next grant.

Test Plan:
- Reset, then single request: req=4'b0100, wdata[2]=8'hA5 → en_out high one cycle at E, q=8'hA5 from E+1, ack=4'b0100 during E+1..E+2, gnt_id=2.
- All requesters active: req=4'b1111 held, wdata[i]=8'h10+i, HOLD=1 → grant order 0,1,2,3,0, q sequence 10,11,12,13,10, consecutive grants 4 cycles apart.
- Fairness after wrap: last grant=3, req=4'b1001 → requester 0 granted next; then requester 3.
- Data stability: change wdata[1] from 8'h33 to 8'hCC one cycle after the grant to requester 1 → q=8'h33. Drop req[1] during WRITE → ack[1] still pulses.
- Reset mid-operation: assert reset in the WRITE cycle → next cycle q=0, ack=0, busy=0; a subsequent req=4'b1000 is granted to requester 3 normally.
- HOLD=0 back-to-back: req=4'b0011 held → grants 3 cycles apart, alternating 0,1; en_out duty exactly 1 cycle in 3.
